// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares one single-port 64-bit data array between the memory stage (port 0,
// read/write) and instruction fetch (port 1, read-only). Round-robin on
// contested cycles, one grant per cycle, one registered response per grant.
// Out-of-range word addresses are granted but never reach the array; their
// response carries err = 1 and zero data.

module dmem_port_arbiter #(
    parameter int DEPTH = 8192,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [63:0]   p0_addr,
    input  logic [63:0]   p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [63:0]   p0_rdata,
    output logic          p0_err,

    input  logic          p1_req,
    input  logic [63:0]   p1_addr,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [63:0]   p1_rdata,
    output logic          p1_err,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [63:0]   mem_wdata,
    input  logic [63:0]   mem_rdata
);

    localparam logic [63:0] DEPTH_W = 64'(DEPTH);

    // last_gnt: port that won the most recent contested cycle (1 after reset,
    // so port 0 wins the first contest).
    logic last_gnt;
    logic resp_valid;
    logic resp_port;
    logic resp_err;
    logic resp_is_read;

    logic p0_oor;
    logic p1_oor;
    logic gnt_err;
    logic gnt_read;

    // Full 64-bit range check; high address bits must not alias into the array.
    assign p0_oor = (p0_addr >= DEPTH_W);
    assign p1_oor = (p1_addr >= DEPTH_W);

    // Grant selection: lone requester wins, contest goes to the port that lost last time.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (p0_req && p1_req) begin
                if (last_gnt) begin
                    p0_gnt = 1'b1;
                end else begin
                    p1_gnt = 1'b1;
                end
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
        end
    end

    // Array drive for the granted port; out-of-range grants leave en/we low.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (p0_gnt) begin
            mem_en    = !p0_oor;
            mem_we    = p0_we && !p0_oor;
            mem_addr  = p0_addr[AW-1:0];
            mem_wdata = p0_wdata;
        end else if (p1_gnt) begin
            mem_en    = !p1_oor;
            mem_addr  = p1_addr[AW-1:0];
        end
    end

    assign gnt_err  = (p0_gnt && p0_oor) || (p1_gnt && p1_oor);
    assign gnt_read = p1_gnt || (p0_gnt && !p0_we);

    // Round-robin pointer and the one-deep response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt     <= 1'b1;
            resp_valid   <= 1'b0;
            resp_port    <= 1'b0;
            resp_err     <= 1'b0;
            resp_is_read <= 1'b0;
        end else begin
            if (p0_req && p1_req) begin
                last_gnt <= p1_gnt;
            end
            resp_valid   <= p0_gnt || p1_gnt;
            resp_port    <= p1_gnt;
            resp_err     <= gnt_err;
            resp_is_read <= gnt_read && !gnt_err;
        end
    end

    // A response still held in the register while reset is asserted is dropped.
    assign p0_rvalid = resp_valid && !resp_port && !rst;
    assign p1_rvalid = resp_valid &&  resp_port && !rst;
    assign p0_err    = p0_rvalid && resp_err;
    assign p1_err    = p1_rvalid && resp_err;
    assign p0_rdata  = (p0_rvalid && resp_is_read) ? mem_rdata : 64'd0;
    assign p1_rdata  = (p1_rvalid && resp_is_read) ? mem_rdata : 64'd0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural 8192 x 64 array.
// Each vector is one clock cycle: inputs are driven 1 ns after the rising
// edge, all outputs are compared at the falling edge.

module tb_dmem_port_arbiter;

    localparam logic [63:0] D0   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D100 = 64'hA5A5_0000_1111_0064;
    localparam logic [63:0] DTOP = 64'hFEED_0000_0000_1FFF;
    localparam logic [63:0] DB   = 64'h0000_0000_DEAD_BEEF;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
    logic [63:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_gnt, p1_rvalid, p1_err;
    logic [63:0] p1_addr, p1_rdata;
    logic        mem_en, mem_we;
    logic [12:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;

    logic [63:0] mem_arr [0:8191];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rst;
        logic        p0_req;
        logic        p0_we;
        logic [63:0] p0_addr;
        logic [63:0] p0_wdata;
        logic        p1_req;
        logic [63:0] p1_addr;
        logic        g0;
        logic        g1;
        logic        en;
        logic        we;
        logic [12:0] addr;
        logic [63:0] wdata;
        logic        r0v;
        logic        r0e;
        logic [63:0] r0d;
        logic        r1v;
        logic        r1e;
        logic [63:0] r1d;
    } vec_t;

    vec_t vt [18];

    dmem_port_arbiter #(.DEPTH(8192), .AW(13)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p0_err    (p0_err),
        .p1_req    (p1_req),
        .p1_addr   (p1_addr),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .p1_err    (p1_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous array: write commits at the edge, read data next cycle.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
        end
    end

    task automatic drive(input vec_t v);
        rst      = v.rst;
        p0_req   = v.p0_req;
        p0_we    = v.p0_we;
        p0_addr  = v.p0_addr;
        p0_wdata = v.p0_wdata;
        p1_req   = v.p1_req;
        p1_addr  = v.p1_addr;
    endtask

    task automatic check(input string name, input vec_t v);
        logic ok;
        logic chk_bus;
        // Address/data lines are only specified when the array is enabled or idle.
        chk_bus = v.en || (!v.g0 && !v.g1);
        ok = (p0_gnt === v.g0) && (p1_gnt === v.g1) && (mem_en === v.en) &&
             (mem_we === v.we) &&
             (!chk_bus || ((mem_addr === v.addr) && (mem_wdata === v.wdata))) &&
             (p0_rvalid === v.r0v) && (p0_err === v.r0e) && (p0_rdata === v.r0d) &&
             (p1_rvalid === v.r1v) && (p1_err === v.r1e) && (p1_rdata === v.r1d);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got gnt=%b%b en=%b we=%b addr=%h wd=%h p0=%b/%b/%h p1=%b/%b/%h, want gnt=%b%b en=%b we=%b addr=%h wd=%h p0=%b/%b/%h p1=%b/%b/%h",
                     name, p0_gnt, p1_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                     p0_rvalid, p0_err, p0_rdata, p1_rvalid, p1_err, p1_rdata,
                     v.g0, v.g1, v.en, v.we, v.addr, v.wdata,
                     v.r0v, v.r0e, v.r0d, v.r1v, v.r1e, v.r1d);
        end
    endtask

    task automatic step(input string name, input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        check(name, v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8192; i++) mem_arr[i] = 64'd0;
        mem_arr[0]    = D0;
        mem_arr[100]  = D100;
        mem_arr[8191] = DTOP;
        mem_rdata     = 64'd0;

        //        rst  p0r  we   p0_addr   p0_wdata  p1r  p1_addr      g0   g1   en   we   addr       wdata     r0v  r0e  r0d    r1v  r1e  r1d
        vt[0]  = '{1'b1,1'b1,1'b0,64'd5,    64'd0,    1'b1,64'd100,     1'b0,1'b0,1'b0,1'b0,13'd0,     64'd0,    1'b0,1'b0,64'd0, 1'b0,1'b0,64'd0};
        vt[1]  = '{1'b1,1'b1,1'b0,64'd5,    64'd0,    1'b1,64'd100,     1'b0,1'b0,1'b0,1'b0,13'd0,     64'd0,    1'b0,1'b0,64'd0, 1'b0,1'b0,64'd0};
        vt[2]  = '{1'b0,1'b1,1'b0,64'd0,    64'd0,    1'b1,64'd100,     1'b1,1'b0,1'b1,1'b0,13'd0,     64'd0,    1'b0,1'b0,64'd0, 1'b0,1'b0,64'd0};
        vt[3]  = '{1'b0,1'b1,1'b0,64'd0,    64'd0,    1'b1,64'd100,     1'b0,1'b1,1'b1,1'b0,13'd100,   64'd0,    1'b1,1'b0,D0,    1'b0,1'b0,64'd0};
        vt[4]  = '{1'b0,1'b1,1'b0,64'd0,    64'd0,    1'b1,64'd100,     1'b1,1'b0,1'b1,1'b0,13'd0,     64'd0,    1'b0,1'b0,64'd0, 1'b1,1'b0,D100};
        vt[5]  = '{1'b0,1'b1,1'b0,64'd0,    64'd0,    1'b1,64'd100,     1'b0,1'b1,1'b1,1'b0,13'd100,   64'd0,    1'b1,1'b0,D0,    1'b0,1'b0,64'd0};
        vt[6]  = '{1'b0,1'b1,1'b0,64'd0,    64'd0,    1'b1,64'd100,     1'b1,1'b0,1'b1,1'b0,13'd0,     64'd0,    1'b0,1'b0,64'd0, 1'b1,1'b0,D100};
        vt[7]  = '{1'b0,1'b1,1'b0,64'd0,    64'd0,    1'b1,64'd100,     1'b0,1'b1,1'b1,1'b0,13'd100,   64'd0,    1'b1,1'b0,D0,    1'b0,1'b0,64'd0};
        vt[8]  = '{1'b0,1'b0,1'b0,64'd0,    64'd0,    1'b0,64'd0,       1'b0,1'b0,1'b0,1'b0,13'd0,     64'd0,    1'b0,1'b0,64'd0, 1'b1,1'b0,D100};
        vt[9]  = '{1'b0,1'b1,1'b1,64'd5,    DB,       1'b0,64'd0,       1'b1,1'b0,1'b1,1'b1,13'd5,     DB,       1'b0,1'b0,64'd0, 1'b0,1'b0,64'd0};
        vt[10] = '{1'b0,1'b1,1'b0,64'd5,    64'd0,    1'b0,64'd0,       1'b1,1'b0,1'b1,1'b0,13'd5,     64'd0,    1'b1,1'b0,64'd0, 1'b0,1'b0,64'd0};
        vt[11] = '{1'b0,1'b0,1'b0,64'd0,    64'd0,    1'b0,64'd0,       1'b0,1'b0,1'b0,1'b0,13'd0,     64'd0,    1'b1,1'b0,DB,    1'b0,1'b0,64'd0};
        vt[12] = '{1'b0,1'b0,1'b0,64'd0,    64'd0,    1'b1,64'd8192,    1'b0,1'b1,1'b0,1'b0,13'd0,     64'd0,    1'b0,1'b0,64'd0, 1'b0,1'b0,64'd0};
        vt[13] = '{1'b0,1'b1,1'b1,ONES,     64'h5555, 1'b0,64'd0,       1'b1,1'b0,1'b0,1'b0,13'd0,     64'd0,    1'b0,1'b0,64'd0, 1'b1,1'b1,64'd0};
        vt[14] = '{1'b0,1'b0,1'b0,64'd0,    64'd0,    1'b0,64'd0,       1'b0,1'b0,1'b0,1'b0,13'd0,     64'd0,    1'b1,1'b1,64'd0, 1'b0,1'b0,64'd0};
        vt[15] = '{1'b0,1'b1,1'b0,64'd0,    64'd0,    1'b0,64'd0,       1'b1,1'b0,1'b1,1'b0,13'd0,     64'd0,    1'b0,1'b0,64'd0, 1'b0,1'b0,64'd0};
        vt[16] = '{1'b0,1'b1,1'b0,64'd8191, 64'd0,    1'b0,64'd0,       1'b1,1'b0,1'b1,1'b0,13'h1FFF,  64'd0,    1'b1,1'b0,D0,    1'b0,1'b0,64'd0};
        vt[17] = '{1'b0,1'b0,1'b0,64'd0,    64'd0,    1'b0,64'd0,       1'b0,1'b0,1'b0,1'b0,13'd0,     64'd0,    1'b1,1'b0,DTOP,  1'b0,1'b0,64'd0};

        drive(vt[0]);
        for (int i = 0; i < 18; i++) begin
            step($sformatf("vec%0d", i), vt[i]);
        end

        // Reset in the middle of an outstanding p1 read: response is dropped and
        // the round-robin pointer returns to favouring port 0.
        step("rr_p0_first", '{1'b0,1'b1,1'b0,64'd0,64'd0,1'b1,64'd100, 1'b1,1'b0,1'b1,1'b0,13'd0,  64'd0, 1'b0,1'b0,64'd0, 1'b0,1'b0,64'd0});
        step("p1_grant",    '{1'b0,1'b0,1'b0,64'd0,64'd0,1'b1,64'd100, 1'b0,1'b1,1'b1,1'b0,13'd100,64'd0, 1'b1,1'b0,D0,    1'b0,1'b0,64'd0});
        step("rst_drop",    '{1'b1,1'b1,1'b0,64'd0,64'd0,1'b1,64'd100, 1'b0,1'b0,1'b0,1'b0,13'd0,  64'd0, 1'b0,1'b0,64'd0, 1'b0,1'b0,64'd0});
        step("post_rst",    '{1'b0,1'b1,1'b0,64'd0,64'd0,1'b1,64'd100, 1'b1,1'b0,1'b1,1'b0,13'd0,  64'd0, 1'b0,1'b0,64'd0, 1'b0,1'b0,64'd0});
        step("post_resp",   '{1'b0,1'b0,1'b0,64'd0,64'd0,1'b0,64'd0,   1'b0,1'b0,1'b0,1'b0,13'd0,  64'd0, 1'b1,1'b0,D0,    1'b0,1'b0,64'd0});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
